mux_scan_sequencer: RTL

Sequencer that drives the 4-bit select of the 16:1 mux tree and reassembles the selected bits into a parallel word. It sits directly upstream of the mux on the select path and downstream of it on the data path.
- A start pulse launches one scan over all select codes.
- One `mux_y` sample is captured per code.
- The assembled 16-bit word is presented on a valid/ready output.

---
 rtl/mux_scan_pkg.sv | 16 +
 rtl/mux_scan_dwell_cnt.sv | 35 +++
 rtl/mux_scan_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux scan sequencer.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StHold
    } state_e;

    localparam int unsigned SEL_W_DEF = 4;

    function automatic int unsigned word_width(input int unsigned sel_w);
        return 32'd1 << sel_w;
    endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Dwell counter: counts while enabled and flags the last cycle of each dwell period.
module mux_scan_dwell_cnt #(
    parameter int unsigned DWELL = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = 4;
    localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == CntLast);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the mux select through every code, captures one mux_y bit per code and
// presents the assembled word on valid/ready. Optional parity output: SCAN_PARITY_EN.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int unsigned SEL_W = SEL_W_DEF,
    parameter int unsigned DWELL = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [SEL_W-1:0]              sel,
    input  logic                          mux_y,
    output logic                          busy,
    output logic [word_width(SEL_W)-1:0]  out_data,
    output logic                          out_valid,
    input  logic                          out_ready
`ifdef SCAN_PARITY_EN
    ,
    output logic                          out_parity
`endif
);

    localparam int unsigned W = word_width(SEL_W);
    localparam logic [SEL_W-1:0] SelLast = '1;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [W-1:0]     data_q, data_d;
    logic             cnt_en, cnt_clr, tick;

    mux_scan_dwell_cnt #(
        .DWELL(DWELL)
    ) u_dwell_cnt (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en),
        .clr (cnt_clr),
        .tick(tick)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        cnt_en  = 1'b0;
        cnt_clr = 1'b1;
        unique case (state_q)
            StIdle: begin
                sel_d = '0;
                // The previous word stays visible until a new scan is accepted.
                if (start) begin
                    state_d = StScan;
                    data_d  = '0;
                end
            end
            StScan: begin
                cnt_en  = 1'b1;
                cnt_clr = 1'b0;
                if (tick) begin
                    data_d[sel_q] = mux_y;
                    if (sel_q == SelLast) begin
                        state_d = StHold;
                        sel_d   = '0;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end
            end
            StHold: begin
                sel_d = '0;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign sel       = sel_q;
    assign busy      = (state_q == StScan);
    assign out_valid = (state_q == StHold);
    assign out_data  = data_q;

`ifdef SCAN_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^data_d;
        end
    end

    assign out_parity = parity_q;
`endif

endmodule
